generador_transacciones: RTL and testbench

- Cajero-side front end that drives the bank card controller's input protocol.
- Captures a complete transaction request (card type, 4-digit BCD PIN, transaction type, amount) on a start pulse.
- Emits the card-received flag, the PIN as four digit strobes, then the amount strobe, and interprets the controller's response flags into one result code.
- Sits between keypad/UI logic and the card controller; owns PIN retry and timeouts.

---
 rtl/atm_pkg.sv | 23 ++
 rtl/generador_transacciones_if.sv | 35 +++
 rtl/serializador_pin.sv | 60 ++++++
 rtl/generador_transacciones.sv | 138 +++++++++++++
 tb/tb_generador_transacciones.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the transaction generator: FSM state encoding,
// result codes and a counter-width helper.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE, CARD, DIGIT, WAIT_PIN, MONTO, WAIT_RESULT, DONE
  } estado_t;

  typedef enum logic [2:0] {
    RES_OK_DEPOSITO = 3'd0,
    RES_OK_RETIRO   = 3'd1,
    RES_FONDOS      = 3'd2,
    RES_PIN_FALLO   = 3'd3,
    RES_BLOQUEO     = 3'd4,
    RES_TIMEOUT     = 3'd5
  } resultado_t;

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/generador_transacciones_if.sv
// Card-controller bus: request side driven by the generator (master),
// response flags driven by the controller (slave).
//   tarjeta_recibida, tipo_tarjeta, digito/digito_stb, tipo_transaccion,
//   monto/monto_stb                                   : master -> slave
//   balance_actualizado, entregar_dinero, fondos_insuficientes,
//   pin_incorrecto, bloqueo, advertencia              : slave -> master
interface generador_transacciones_if;
  logic        tarjeta_recibida;
  logic        tipo_tarjeta;
  logic [3:0]  digito;
  logic        digito_stb;
  logic        tipo_transaccion;
  logic [31:0] monto;
  logic        monto_stb;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic        pin_incorrecto;
  logic        bloqueo;
  logic        advertencia;

  modport master (
    output tarjeta_recibida, tipo_tarjeta, digito, digito_stb,
           tipo_transaccion, monto, monto_stb,
    input  balance_actualizado, entregar_dinero, fondos_insuficientes,
           pin_incorrecto, bloqueo, advertencia
  );

  modport slave (
    input  tarjeta_recibida, tipo_tarjeta, digito, digito_stb,
           tipo_transaccion, monto, monto_stb,
    output balance_actualizado, entregar_dinero, fondos_insuficientes,
           pin_incorrecto, bloqueo, advertencia
  );
endinterface

// File: rtl/serializador_pin.sv
// PIN serializer: on load, emits the four BCD nibbles of pin (MSB nibble
// first) as one-cycle strobes separated by DIGIT_GAP idle cycles.
//   clk, rst (sync, active-low), load : control
//   pin    : 16-bit PIN, must stay stable while sending
//   digito : current nibble (0 outside a strobe)
//   stb    : digit strobe; fin : high together with the 4th strobe
module serializador_pin #(
  parameter int DIGIT_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] pin,
  output logic [3:0]  digito,
  output logic        stb,
  output logic        fin
);
  localparam int GW = (DIGIT_GAP > 0) ? $clog2(DIGIT_GAP + 1) : 1;

  logic          activo;
  logic [1:0]    idx;
  logic [GW-1:0] gap;
  logic [3:0]    nib;

  // A strobe fires whenever the gap countdown has drained.
  assign stb    = activo && (gap == '0);
  assign fin    = stb && (idx == 2'd3);
  assign digito = stb ? nib : 4'h0;

  always_comb begin
    nib = pin[15:12];
    case (idx)
      2'd0: nib = pin[15:12];
      2'd1: nib = pin[11:8];
      2'd2: nib = pin[7:4];
      2'd3: nib = pin[3:0];
      default: nib = pin[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      activo <= 1'b0;
      idx    <= 2'd0;
      gap    <= '0;
    end else if (load) begin
      activo <= 1'b1;
      idx    <= 2'd0;
      gap    <= '0;
    end else if (activo) begin
      if (stb) begin
        idx <= idx + 2'd1;
        gap <= GW'(DIGIT_GAP);
        if (idx == 2'd3) activo <= 1'b0;
      end else begin
        gap <= gap - 1'b1;
      end
    end
  end
endmodule

// File: rtl/generador_transacciones.sv
// Cashier-side front end for the card controller. Captures a request on
// start, presents the card, sends the PIN (with retries), sends the amount
// and folds the controller's response flags into one result code.
//   clk, rst (sync, active-low)
//   start, tipo_tarjeta_in, pin_in, tipo_transaccion_in, monto_in : request
//   bus      : controller side (master modport)
//   busy, done, resultado, intentos : status towards the UI
module generador_transacciones
  import atm_pkg::*;
#(
  parameter int DIGIT_GAP    = 1,
  parameter int PIN_WAIT     = 8,
  parameter int TIMEOUT      = 64,
  parameter int MAX_INTENTOS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tipo_tarjeta_in,
  input  logic [15:0] pin_in,
  input  logic        tipo_transaccion_in,
  input  logic [31:0] monto_in,
  generador_transacciones_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [2:0]  resultado,
  output logic [1:0]  intentos
);
  localparam int CW = (cnt_w(PIN_WAIT) > cnt_w(TIMEOUT)) ? cnt_w(PIN_WAIT) : cnt_w(TIMEOUT);
  localparam logic [CW-1:0] PIN_LAST = CW'(PIN_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [1:0]    MAX_I    = 2'(MAX_INTENTOS);

  estado_t     state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]  res_n;
  logic [1:0]  int_n;
  logic        load, fin;
  logic [15:0] pin_r;
  logic        tt_r, tx_r;
  logic [31:0] monto_r;

  serializador_pin #(.DIGIT_GAP(DIGIT_GAP)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .pin    (pin_r),
    .digito (bus.digito),
    .stb    (bus.digito_stb),
    .fin    (fin)
  );

  assign busy                 = (state != IDLE);
  assign done                 = (state == DONE);
  assign bus.tarjeta_recibida = busy;
  assign bus.monto_stb        = (state == MONTO);
  assign bus.tipo_tarjeta     = tt_r;
  assign bus.tipo_transaccion = tx_r;
  assign bus.monto            = monto_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      resultado <= '0;
      intentos  <= '0;
      pin_r     <= '0;
      tt_r      <= 1'b0;
      tx_r      <= 1'b0;
      monto_r   <= '0;
    end else begin
      state     <= state_n;
      resultado <= res_n;
      intentos  <= int_n;
      // Only the two waiting states count; any state change restarts it.
      if (state_n != state || !(state == WAIT_PIN || state == WAIT_RESULT))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == IDLE && start) begin
        pin_r   <= pin_in;
        tt_r    <= tipo_tarjeta_in;
        tx_r    <= tipo_transaccion_in;
        monto_r <= monto_in;
      end
    end
  end

  always_comb begin
    state_n = state;
    res_n   = resultado;
    int_n   = intentos;
    load    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = CARD;
        int_n   = 2'd0;
        res_n   = 3'd0;
      end
      CARD: begin
        state_n = DIGIT;
        load    = 1'b1;
      end
      DIGIT: if (fin) begin
        int_n   = intentos + 2'd1;
        state_n = WAIT_PIN;
      end
      WAIT_PIN: begin
        if (bus.bloqueo) begin
          res_n   = RES_BLOQUEO;
          state_n = DONE;
        end else if (bus.pin_incorrecto) begin
          if (intentos < MAX_I) begin
            load    = 1'b1;
            state_n = DIGIT;
          end else begin
            res_n   = RES_PIN_FALLO;
            state_n = DONE;
          end
        end else if (cnt == PIN_LAST) begin
          state_n = MONTO;
        end
      end
      MONTO: state_n = WAIT_RESULT;
      WAIT_RESULT: begin
        state_n = DONE;
        if (bus.bloqueo)                                          res_n = RES_BLOQUEO;
        else if (bus.fondos_insuficientes)                        res_n = RES_FONDOS;
        else if (!tx_r && bus.balance_actualizado)                res_n = RES_OK_DEPOSITO;
        else if (tx_r && bus.balance_actualizado && bus.entregar_dinero) res_n = RES_OK_RETIRO;
        else if (cnt == TO_LAST)                                  res_n = RES_TIMEOUT;
        else                                                      state_n = WAIT_RESULT;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_generador_transacciones.sv
// Directed bench for generador_transacciones: a small responder drives the
// controller flags, a negedge monitor records strobes, and chk compares.
module tb_generador_transacciones;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        tt_in = 1'b0;
  logic        tx_in = 1'b0;
  logic [15:0] pin_in = '0;
  logic [31:0] monto_in = '0;
  logic        busy, done;
  logic [2:0]  resultado;
  logic [1:0]  intentos;

  generador_transacciones_if bus();

  generador_transacciones #(
    .DIGIT_GAP(1), .PIN_WAIT(8), .TIMEOUT(64), .MAX_INTENTOS(3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .tipo_tarjeta_in     (tt_in),
    .pin_in              (pin_in),
    .tipo_transaccion_in (tx_in),
    .monto_in            (monto_in),
    .bus                 (bus),
    .busy                (busy),
    .done                (done),
    .resultado           (resultado),
    .intentos            (intentos)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0, cyc = 0;
  logic [3:0]  digs[$];
  int          stb_cyc[$];
  int          n_monto = 0, n_done = 0;
  logic [31:0] monto_seen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.digito_stb) begin
      digs.push_back(bus.digito);
      stb_cyc.push_back(cyc);
    end
    if (bus.monto_stb) begin
      n_monto++;
      monto_seen = bus.monto;
    end
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic tt, input logic [15:0] p, input logic tx, input logic [31:0] m);
    digs.delete();
    stb_cyc.delete();
    n_monto = 0;
    n_done  = 0;
    tt_in = tt; pin_in = p; tx_in = tx; monto_in = m;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("card_tarjeta", bus.tarjeta_recibida, 1);
    chk("card_busy", busy, 1);
  endtask

  // kind 0: done, 1: monto_stb, 2: at least n digit strobes seen
  task automatic wait_for(input string tag, input int kind, input int n, output int w);
    logic ok;
    ok = 1'b0;
    w  = 0;
    for (int i = 0; i < 300; i++) begin
      if ((kind == 0 && done) || (kind == 1 && bus.monto_stb) ||
          (kind == 2 && digs.size() >= n)) begin
        ok = 1'b1;
        break;
      end
      step();
      w++;
    end
    chk({tag, "_reached"}, ok, 1);
  endtask

  initial begin
    int w;
    bus.balance_actualizado  = 1'b0;
    bus.entregar_dinero      = 1'b0;
    bus.fondos_insuficientes = 1'b0;
    bus.pin_incorrecto       = 1'b0;
    bus.bloqueo              = 1'b0;
    bus.advertencia          = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", resultado, 0);
    chk("rst_int", intentos, 0);
    chk("rst_tarjeta", bus.tarjeta_recibida, 0);
    rst = 1'b1;
    step();

    // Deposit, controller confirms 3 cycles after monto_stb
    go(1'b0, 16'h3721, 1'b0, 32'd500);
    wait_for("dep_monto", 1, 0, w);
    chk("dep_monto_val", monto_seen, 500);
    repeat (3) step();
    bus.balance_actualizado = 1'b1;
    wait_for("dep_done", 0, 0, w);
    bus.balance_actualizado = 1'b0;
    chk("dep_res", resultado, 0);
    chk("dep_int", intentos, 1);
    chk("dep_ndig", digs.size(), 4);
    chk("dep_d0", digs[0], 3);
    chk("dep_d1", digs[1], 7);
    chk("dep_d2", digs[2], 2);
    chk("dep_d3", digs[3], 1);
    for (int k = 0; k < 3; k++) chk("dep_gap", stb_cyc[k+1] - stb_cyc[k], 2);
    chk("dep_nmonto", n_monto, 1);
    step();
    chk("dep_done_pulse", done, 0);
    chk("dep_idle", busy, 0);
    chk("dep_res_hold", resultado, 0);

    // Withdrawal with insufficient funds
    go(1'b0, 16'h0409, 1'b1, 32'd9000);
    wait_for("fon_monto", 1, 0, w);
    step();
    bus.fondos_insuficientes = 1'b1;
    wait_for("fon_done", 0, 0, w);
    bus.fondos_insuficientes = 1'b0;
    chk("fon_res", resultado, 2);
    chk("fon_monto_out", bus.monto, 9000);
    chk("fon_tipo_tx", bus.tipo_transaccion, 1);
    step();

    // Wrong PIN twice, accepted on the third attempt
    go(1'b1, 16'h2580, 1'b1, 32'd1234);
    for (int a = 0; a < 2; a++) begin
      wait_for("rec_dig", 2, 4 * (a + 1), w);
      step();
      bus.pin_incorrecto = 1'b1;
      step();
      bus.pin_incorrecto = 1'b0;
    end
    wait_for("rec_monto", 1, 0, w);
    step();
    bus.balance_actualizado = 1'b1;
    bus.entregar_dinero     = 1'b1;
    wait_for("rec_done", 0, 0, w);
    bus.balance_actualizado = 1'b0;
    bus.entregar_dinero     = 1'b0;
    chk("rec_res", resultado, 1);
    chk("rec_int", intentos, 3);
    chk("rec_ndig", digs.size(), 12);
    chk("rec_d8", digs[8], 2);
    chk("rec_d11", digs[11], 0);
    chk("rec_nmonto", n_monto, 1);
    chk("rec_tipo_tarjeta", bus.tipo_tarjeta, 1);
    step();

    // Wrong PIN on all three attempts
    go(1'b0, 16'h9999, 1'b0, 32'd10);
    for (int a = 0; a < 3; a++) begin
      wait_for("exh_dig", 2, 4 * (a + 1), w);
      step();
      bus.pin_incorrecto = 1'b1;
      step();
      bus.pin_incorrecto = 1'b0;
    end
    wait_for("exh_done", 0, 0, w);
    chk("exh_res", resultado, 3);
    chk("exh_int", intentos, 3);
    chk("exh_nmonto", n_monto, 0);
    step();

    // Lockout while waiting for PIN acceptance
    go(1'b0, 16'h1234, 1'b0, 32'd77);
    wait_for("blq_dig", 2, 4, w);
    step();
    bus.bloqueo = 1'b1;
    step();
    bus.bloqueo = 1'b0;
    chk("blq_done_now", done, 1);
    chk("blq_res", resultado, 4);
    chk("blq_nmonto", n_monto, 0);
    step();

    // Silent controller: timeout, with advertencia toggled to no effect
    go(1'b0, 16'h1111, 1'b0, 32'd42);
    bus.advertencia = 1'b1;
    wait_for("to_monto", 1, 0, w);
    wait_for("to_done", 0, 0, w);
    bus.advertencia = 1'b0;
    chk("to_latency", w, 65);
    chk("to_res", resultado, 5);
    step();

    // Reset during the second digit strobe
    go(1'b1, 16'h4812, 1'b1, 32'd777);
    wait_for("rs_dig", 2, 2, w);
    chk("rs_in_stb", bus.digito_stb, 1);
    rst = 1'b0;
    step();
    chk("rs_busy", busy, 0);
    chk("rs_tarjeta", bus.tarjeta_recibida, 0);
    chk("rs_stb", bus.digito_stb, 0);
    chk("rs_digito", bus.digito, 0);
    chk("rs_monto", bus.monto, 0);
    chk("rs_tt", bus.tipo_tarjeta, 0);
    chk("rs_tx", bus.tipo_transaccion, 0);
    chk("rs_res", resultado, 0);
    chk("rs_int", intentos, 0);
    rst = 1'b1;
    repeat (10) step();
    chk("rs_no_done", n_done, 0);
    chk("rs_ndig", digs.size(), 2);

    // start while busy and during DONE is ignored
    go(1'b1, 16'h5555, 1'b0, 32'd111);
    repeat (3) step();
    tt_in = 1'b0; pin_in = 16'h9999; monto_in = 32'd999; tx_in = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_for("bz_monto", 1, 0, w);
    chk("bz_monto_val", monto_seen, 111);
    chk("bz_tt", bus.tipo_tarjeta, 1);
    chk("bz_d3", digs[3], 5);
    step();
    bus.balance_actualizado = 1'b1;
    wait_for("bz_done", 0, 0, w);
    bus.balance_actualizado = 1'b0;
    chk("bz_res", resultado, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("bz_done_start", busy, 0);
    step();
    chk("bz_still_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
